// File: rtl/aul_pkg.sv
// aul shared definitions: ALU mode encodings and default width.
// Optional flags output is enabled with macro AUL_FLAGS_EN.
package aul_pkg;

    localparam int AUL_W = 16;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

endpackage

// File: rtl/aul_if.sv
// aul bus interface: operand buses, strobes and shared tri-state output.
// Flag outputs exist only when AUL_FLAGS_EN is defined.
interface aul_if
    import aul_pkg::*;
#(
    parameter int N = AUL_W
);

    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   ALU_mode;
    logic         ain;
    logic         gin;
    logic         gout;
    wire  [N-1:0] ALUout;
`ifdef AUL_FLAGS_EN
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;
`endif

    modport master (
        output a,
        output b,
        output ALU_mode,
        output ain,
        output gin,
        output gout,
`ifdef AUL_FLAGS_EN
        input  flag_z,
        input  flag_n,
        input  flag_c,
        input  flag_v,
`endif
        input  ALUout
    );

    modport slave (
        input  a,
        input  b,
        input  ALU_mode,
        input  ain,
        input  gin,
        input  gout,
`ifdef AUL_FLAGS_EN
        output flag_z,
        output flag_n,
        output flag_c,
        output flag_v,
`endif
        output ALUout
    );

endinterface

// File: rtl/aul_core.sv
// aul function unit: combinational add/sub/xor/and with carry and overflow.
// Sub is A + ~b + 1, so carry reads as NOT borrow.
module aul_core
    import aul_pkg::*;
#(
    parameter int N = AUL_W
) (
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic [1:0]   mode,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         ovf
);

    logic         is_sub;
    logic [N-1:0] b_eff;
    logic [N:0]   sum;
    logic         sum_v;

    // Shared adder for add and sub; sub inverts b and injects carry-in.
    always_comb begin
        is_sub = (mode == ALU_SUB);
        b_eff  = is_sub ? ~op_b : op_b;
        sum    = {1'b0, op_a} + {1'b0, b_eff}
               + {{N{1'b0}}, is_sub};
        sum_v  = (op_a[N-1] == b_eff[N-1])
              && (sum[N-1] != op_a[N-1]);
    end

    // Select the result; carry and overflow are zero for logic ops.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (1'b1)
            (mode == ALU_ADD),
            (mode == ALU_SUB): begin
                result = sum[N-1:0];
                carry  = sum[N];
                ovf    = sum_v;
            end
            (mode == ALU_XOR): begin
                result = op_a ^ op_b;
            end
            default: begin
                result = op_a & op_b;
            end
        endcase
    end

endmodule

// File: rtl/aul.sv
// aul top: A and G registers, optional flags, tri-state result driver.
// Define AUL_FLAGS_EN to add registered z/n/c/v flag outputs.
module aul
    import aul_pkg::*;
#(
    parameter int N = AUL_W
) (
    input logic clk,
    input logic rst,
    aul_if.slave bus
);

    logic [N-1:0] a_q;
    logic [N-1:0] a_d;
    logic [N-1:0] g_q;
    logic [N-1:0] g_d;
    logic [N-1:0] res;
    logic         res_c;
    logic         res_v;

    aul_core #(.N(N)) u_core (
        .op_a   (a_q),
        .op_b   (bus.b),
        .mode   (bus.ALU_mode),
        .result (res),
        .carry  (res_c),
        .ovf    (res_v)
    );

    // Next state: A follows a on ain, G takes the result of the old A.
    always_comb begin
        a_d = a_q;
        g_d = g_q;
        if (bus.ain) a_d = bus.a;
        if (bus.gin) g_d = res;
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            g_q <= '0;
        end else begin
            a_q <= a_d;
            g_q <= g_d;
        end
    end

    // G goes onto the shared bus only while gout is high.
    assign bus.ALUout = bus.gout ? g_q : {N{1'bz}};

`ifdef AUL_FLAGS_EN
    logic [3:0] fl_q;
    logic [3:0] fl_d;

    // Flags {z,n,c,v} refresh only when G loads.
    always_comb begin
        fl_d = fl_q;
        if (bus.gin) begin
            fl_d = {(res == '0), res[N-1], res_c, res_v};
        end
    end

    // Flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) fl_q <= '0;
        else     fl_q <= fl_d;
    end

    assign bus.flag_z = fl_q[3];
    assign bus.flag_n = fl_q[2];
    assign bus.flag_c = fl_q[1];
    assign bus.flag_v = fl_q[0];
`else
    logic unused_flags;
    assign unused_flags = &{1'b0, res_c, res_v};
`endif

endmodule

// File: tb/tb_aul.sv
// aul bench: directed literal cases plus random strobes vs a reference model.
// A bench-side bus driver shares ALUout whenever gout is low.
module tb_aul;
    import aul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic        ain;
    logic        gin;
    logic        gout;
    logic [15:0] pat;
    logic        mon_en = 1'b0;

    int vecs = 0;
    int errs = 0;

    // reference model state
    logic [15:0] m_a;
    logic [15:0] m_g;
    logic        m_z, m_n, m_c, m_v;

    always #5 clk = ~clk;

    aul_if #(.N(16)) bus ();

    assign bus.a        = a;
    assign bus.b        = b;
    assign bus.ALU_mode = mode;
    assign bus.ain      = ain;
    assign bus.gin      = gin;
    assign bus.gout     = gout;
    assign bus.ALUout   = gout ? 16'bz : pat;

    aul #(.N(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Plain integer arithmetic reference for one G load.
    task automatic ref_op(input int ua, input int ub, input int md,
                          output logic [15:0] r, output logic c,
                          output logic v);
        int s;
        int sv;
        c = 1'b0;
        v = 1'b0;
        case (md)
            0: begin
                s  = ua + ub;
                sv = sx(ua) + sx(ub);
                c  = (s > 65535);
                v  = (sv > 32767) || (sv < -32768);
            end
            1: begin
                s  = ua - ub;
                sv = sx(ua) - sx(ub);
                c  = (ua >= ub);
                v  = (sv > 32767) || (sv < -32768);
            end
            2: s = ua ^ ub;
            default: s = ua & ub;
        endcase
        r = s[15:0];
    endtask

    // Model advances on every rising edge from the stable inputs.
    always @(posedge clk) begin
        logic [15:0] r;
        logic c, v;
        if (rst) begin
            m_a = 0; m_g = 0;
            {m_z, m_n, m_c, m_v} = 4'b0;
        end else begin
            if (gin) begin
                ref_op(int'(m_a), int'(b), int'(mode), r, c, v);
                m_g = r;
                m_z = (r == 16'd0);
                m_n = r[15];
                m_c = c;
                m_v = v;
            end
            if (ain) m_a = a;
        end
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_out", bus.ALUout, gout ? m_g : pat);
`ifdef AUL_FLAGS_EN
            chk("mon_flags", {12'd0, bus.flag_z, bus.flag_n,
                              bus.flag_c, bus.flag_v},
                {12'd0, m_z, m_n, m_c, m_v});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        rst = 1'b0;
        ain = 1'b0;
        gin = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ain = 1'b0; gin = 1'b0; gout = 1'b1;
        a = '0; b = '0; mode = ALU_ADD; pat = 16'h5A5A;
        tick();
        mon_en = 1'b1;
        chk("reset_out", bus.ALUout, 16'h0000);

        a = 16'h0002; ain = 1'b1; tick();
        b = 16'h0003; mode = ALU_ADD; gin = 1'b1; tick();
        chk("add", bus.ALUout, 16'h0005);
        gout = 1'b0; #1;
        chk("add_release", bus.ALUout, 16'h5A5A);
        gout = 1'b1;

        mode = ALU_SUB; gin = 1'b1; tick();
        chk("sub_wrap", bus.ALUout, 16'hFFFF);
`ifdef AUL_FLAGS_EN
        chk("sub_flags", {13'd0, bus.flag_z, bus.flag_n, bus.flag_c},
            16'h0002);
`endif

        a = 16'hAA8F; ain = 1'b1; tick();
        b = 16'h558F; mode = ALU_XOR; gin = 1'b1; tick();
        chk("xor", bus.ALUout, 16'hFF00);

        a = 16'h0005; ain = 1'b1; tick();
        a = 16'h0010; b = 16'h0001; mode = ALU_ADD;
        ain = 1'b1; gin = 1'b1; tick();
        chk("same_edge_g", bus.ALUout, 16'h0006);
        gin = 1'b1; tick();
        chk("same_edge_next", bus.ALUout, 16'h0011);

        a = 16'h1234; ain = 1'b1; tick();
        b = 16'h0000; gin = 1'b1; tick();
        chk("load_1234", bus.ALUout, 16'h1234);
        rst = 1'b1; gin = 1'b1; #1;
        chk("rst_no_edge", bus.ALUout, 16'h1234);
        tick();
        chk("rst_mid_op", bus.ALUout, 16'h0000);
        ain = 1'b0; gin = 1'b1; b = 16'h0007; tick();
        chk("rst_cleared_a", bus.ALUout, 16'h0007);

        a = 16'h7FFF; ain = 1'b1; tick();
        b = 16'h0000; gin = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            b = 16'(i * 16'h1111 + 3);
            mode = 2'(i);
            tick();
            chk("hold", bus.ALUout, 16'h7FFF);
        end
        b = 16'h0001; mode = ALU_ADD; gin = 1'b1; tick();
        chk("ovf_add", bus.ALUout, 16'h8000);
`ifdef AUL_FLAGS_EN
        chk("ovf_flag_v", {15'd0, bus.flag_v}, 16'h0001);
`endif

        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 31) == 0);
            ain  = $urandom_range(0, 1) == 1;
            gin  = $urandom_range(0, 1) == 1;
            gout = $urandom_range(0, 3) != 0;
            a    = 16'($urandom);
            b    = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            pat  = 16'($urandom);
            tick();
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
